// File: rtl/dev_irq_ctrl_pkg.sv
// rtl/dev_irq_ctrl_pkg.sv - shared types and constants for the IRQ control table sequencer
package dev_irq_ctrl_pkg;

  localparam int L_PARAM_ENTRY_NUM = 32;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_BULK  = 2'b01,
    OP_READ  = 2'b10,
    OP_NOP   = 2'b11
  } irq_ctrl_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BULK = 1'b1
  } irq_ctrl_state_t;

  typedef struct packed {
    logic       mask;
    logic       valid;
    logic [1:0] mode;
  } irq_ctrl_entry_t;

  typedef struct packed {
    irq_ctrl_op_t    op;
    logic [4:0]      entry;
    irq_ctrl_entry_t data;
  } irq_ctrl_cmd_t;

endpackage

// File: rtl/dev_irq_ctrl_cmd_fifo.sv
// rtl/dev_irq_ctrl_cmd_fifo.sv - synchronous command FIFO with full/empty flags
module dev_irq_ctrl_cmd_fifo #(
  parameter int P_DEPTH = 4,
  parameter int P_WIDTH = 11
)(
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iPUSH,
  input  logic [P_WIDTH-1:0] iDATA,
  input  logic               iPOP,
  output logic [P_WIDTH-1:0] oDATA,
  output logic               oFULL,
  output logic               oEMPTY
);

  localparam int L_AW = $clog2(P_DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [L_AW:0]        wr_ptr;
  logic [L_AW:0]        rd_ptr;
  logic [P_WIDTH-1:0]   mem [P_DEPTH];
  logic                 push_ok;
  logic                 pop_ok;

  assign oEMPTY  = (wr_ptr == rd_ptr);
  assign oFULL   = (wr_ptr[L_AW] != rd_ptr[L_AW]) &&
                   (wr_ptr[L_AW-1:0] == rd_ptr[L_AW-1:0]);
  assign push_ok = iPUSH && !oFULL;
  assign pop_ok  = iPOP && !oEMPTY;
  assign oDATA   = mem[rd_ptr[L_AW-1:0]];

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (push_ok) mem[wr_ptr[L_AW-1:0]] <= iDATA;
  end

endmodule

// File: rtl/dev_irq_ctrl_sequencer.sv
// rtl/dev_irq_ctrl_sequencer.sv - queues IRQ table commands and drives one table write per cycle
module dev_irq_ctrl_sequencer
  import dev_irq_ctrl_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 4,
  parameter int P_ENTRY_NUM  = L_PARAM_ENTRY_NUM
)(
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic       iCMD_REQ,
  output logic       oCMD_BUSY,
  input  logic [1:0] iCMD_OP,
  input  logic [4:0] iCMD_ENTRY,
  input  logic       iCMD_MASK,
  input  logic       iCMD_VALID,
  input  logic [1:0] iCMD_MODE,
  output logic       oRD_VALID,
  output logic       oRD_MASK,
  output logic       oRD_VLD,
  output logic [1:0] oRD_MODE,
  output logic       oIRQ_CTRL_REQ,
  output logic [4:0] oIRQ_CTRL_ENTRY,
  output logic       oIRQ_CTRL_INFO_MASK,
  output logic       oIRQ_CTRL_INFO_VALID,
  output logic [1:0] oIRQ_CTRL_INFO_MODE,
  output logic       oIDLE
);

  localparam int         L_CMD_W      = $bits(irq_ctrl_cmd_t);
  localparam logic [4:0] L_LAST_ENTRY = 5'(P_ENTRY_NUM - 1);

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [L_CMD_W-1:0] cmd_bits;
  logic [L_CMD_W-1:0] head_bits;
  irq_ctrl_cmd_t      head;

  irq_ctrl_state_t    state, state_next;
  logic [4:0]         cnt, cnt_next;
  irq_ctrl_entry_t    bulk_data, bulk_data_next;

  logic               req_q, req_next;
  logic [4:0]         wr_entry_q, wr_entry_next;
  irq_ctrl_entry_t    wr_data_q, wr_data_next;
  logic               rd_valid_q, rd_valid_next;
  irq_ctrl_entry_t    rd_data_q, rd_data_next;

  irq_ctrl_entry_t    shadow [P_ENTRY_NUM];

  assign cmd_bits = {iCMD_OP, iCMD_ENTRY, iCMD_MASK, iCMD_VALID, iCMD_MODE};
  assign head     = irq_ctrl_cmd_t'(head_bits);

  dev_irq_ctrl_cmd_fifo #(
    .P_DEPTH (P_FIFO_DEPTH),
    .P_WIDTH (L_CMD_W)
  ) u_cmd_fifo (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .iPUSH   (iCMD_REQ),
    .iDATA   (cmd_bits),
    .iPOP    (fifo_pop),
    .oDATA   (head_bits),
    .oFULL   (fifo_full),
    .oEMPTY  (fifo_empty)
  );

  // BULK issues entry 0 on the pop edge so the walk starts with the same latency as a WRITE.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    bulk_data_next = bulk_data;
    fifo_pop       = 1'b0;
    req_next       = 1'b0;
    wr_entry_next  = wr_entry_q;
    wr_data_next   = wr_data_q;
    rd_valid_next  = 1'b0;
    rd_data_next   = rd_data_q;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          case (head.op)
            OP_WRITE: begin
              req_next      = 1'b1;
              wr_entry_next = head.entry;
              wr_data_next  = head.data;
            end
            OP_READ: begin
              rd_valid_next = 1'b1;
              rd_data_next  = shadow[head.entry];
            end
            OP_BULK: begin
              req_next       = 1'b1;
              wr_entry_next  = 5'd0;
              wr_data_next   = head.data;
              bulk_data_next = head.data;
              cnt_next       = 5'd1;
              state_next     = S_BULK;
            end
            default: ;
          endcase
        end
      end
      S_BULK: begin
        req_next      = 1'b1;
        wr_entry_next = cnt;
        wr_data_next  = bulk_data;
        cnt_next      = cnt + 5'd1;
        if (cnt == L_LAST_ENTRY) begin
          cnt_next   = 5'd0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bulk_data  <= '0;
      req_q      <= 1'b0;
      wr_entry_q <= '0;
      wr_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bulk_data  <= bulk_data_next;
      req_q      <= req_next;
      wr_entry_q <= wr_entry_next;
      wr_data_q  <= wr_data_next;
      rd_valid_q <= rd_valid_next;
      rd_data_q  <= rd_data_next;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      for (int i = 0; i < P_ENTRY_NUM; i++) shadow[i] <= '0;
    end else if (req_next) begin
      shadow[wr_entry_next] <= wr_data_next;
    end
  end

  assign oCMD_BUSY            = fifo_full;
  assign oIDLE                = fifo_empty && (state == S_IDLE);
  assign oIRQ_CTRL_REQ        = req_q;
  assign oIRQ_CTRL_ENTRY      = wr_entry_q;
  assign oIRQ_CTRL_INFO_MASK  = wr_data_q.mask;
  assign oIRQ_CTRL_INFO_VALID = wr_data_q.valid;
  assign oIRQ_CTRL_INFO_MODE  = wr_data_q.mode;
  assign oRD_VALID            = rd_valid_q;
  assign oRD_MASK             = rd_data_q.mask;
  assign oRD_VLD              = rd_data_q.valid;
  assign oRD_MODE             = rd_data_q.mode;

endmodule
